// File: rtl/ram_dp_sr_sw_be.sv
// True dual-port RAM with per-byte write enables, selectable same-port
// read-during-write behaviour and a post-reset clear sequencer.
// Port A has byte priority over port B when both write the same word.
module ram_dp_sr_sw_be #(
    parameter int                DATA_W   = 16,
    parameter int                ADDR_W   = 4,
    parameter int                RD_MODE  = 0,
    parameter int                INIT_CLR = 1,
    parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                cs_a,
    input  logic                we_a,
    input  logic                oe_a,
    input  logic [DATA_W/8-1:0] be_a,
    input  logic [ADDR_W-1:0]   addr_a,
    input  logic [DATA_W-1:0]   din_a,
    output logic [DATA_W-1:0]   dout_a,
    input  logic                cs_b,
    input  logic                we_b,
    input  logic                oe_b,
    input  logic [DATA_W/8-1:0] be_b,
    input  logic [ADDR_W-1:0]   addr_b,
    input  logic [DATA_W-1:0]   din_b,
    output logic [DATA_W-1:0]   dout_b,
    output logic                init_busy
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int NB    = DATA_W / 8;

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    state_t              state_reg, state_next;
    logic [ADDR_W-1:0]   ptr_reg, ptr_next;
    logic [DATA_W-1:0]   mem [DEPTH];
    logic [DATA_W-1:0]   rdata_a_reg, rdata_b_reg;
    logic [DATA_W-1:0]   old_a, old_b;
    logic [DATA_W-1:0]   post_a, post_b;
    logic [DATA_W-1:0]   rd_word_a, rd_word_b;
    logic                clearing;
    logic                wr_a, wr_b;
    logic                same_addr;

    assign clearing  = (state_reg == CLEAR);
    assign init_busy = clearing;

    // User accesses are locked out while the clear sequencer owns the array.
    assign wr_a      = cs_a & we_a & ~clearing;
    assign wr_b      = cs_b & we_b & ~clearing;
    assign same_addr = (addr_a == addr_b);

    assign old_a = mem[addr_a];
    assign old_b = mem[addr_b];

    // Post-write word as seen from each port, including a colliding write
    // from the other port (port A owns any byte it enables).
    for (genvar gi = 0; gi < NB; gi++) begin : g_merge
        assign post_a[8*gi +: 8] = (wr_a && be_a[gi])              ? din_a[8*gi +: 8] :
                                   (wr_b && be_b[gi] && same_addr) ? din_b[8*gi +: 8] :
                                                                     old_a[8*gi +: 8];
        assign post_b[8*gi +: 8] = (wr_a && be_a[gi] && same_addr) ? din_a[8*gi +: 8] :
                                   (wr_b && be_b[gi])              ? din_b[8*gi +: 8] :
                                                                     old_b[8*gi +: 8];
    end

    // Write-first only applies when the reading port is itself writing;
    // a pure reader always sees the pre-write word.
    assign rd_word_a = (RD_MODE == 1 && wr_a) ? post_a : old_a;
    assign rd_word_b = (RD_MODE == 1 && wr_b) ? post_b : old_b;

    // Clear sequencer state and pointer.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg <= (INIT_CLR != 0) ? CLEAR : IDLE;
            ptr_reg   <= '0;
        end else begin
            state_reg <= state_next;
            ptr_reg   <= ptr_next;
        end
    end

    // Clear walks every address once, then hands the array to the ports.
    always_comb begin
        state_next = state_reg;
        ptr_next   = ptr_reg;
        if (state_reg == CLEAR) begin
            ptr_next = ptr_reg + 1'b1;
            if (ptr_reg == ADDR_W'(DEPTH - 1)) begin
                state_next = IDLE;
            end
        end
    end

    // Registered read data; held at zero during clear and on cs=0 holds.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rdata_a_reg <= '0;
            rdata_b_reg <= '0;
        end else if (clearing) begin
            rdata_a_reg <= '0;
            rdata_b_reg <= '0;
        end else begin
            if (cs_a) rdata_a_reg <= rd_word_a;
            if (cs_b) rdata_b_reg <= rd_word_b;
        end
    end

    // Array writes: clear fill, else byte writes with B first so A's
    // later assignment wins on a same-word collision.
    always_ff @(posedge clk) begin
        if (clearing) begin
            mem[ptr_reg] <= INIT_VAL;
        end else begin
            for (int i = 0; i < NB; i++) begin
                if (wr_b && be_b[i]) mem[addr_b][8*i +: 8] <= din_b[8*i +: 8];
                if (wr_a && be_a[i]) mem[addr_a][8*i +: 8] <= din_a[8*i +: 8];
            end
        end
    end

    assign dout_a = oe_a ? rdata_a_reg : '0;
    assign dout_b = oe_b ? rdata_b_reg : '0;

endmodule

// File: tb/tb_ram_dp_sr_sw_be.sv
// Scoreboard bench: two RAM instances (read-first and write-first) see the
// same stimulus; expectations are queued with a due cycle and a monitor
// compares them on the falling edge.
module tb_ram_dp_sr_sw_be;

    logic        clk;
    logic        resetn;
    logic        cs_a, we_a, oe_a, cs_b, we_b, oe_b;
    logic [1:0]  be_a, be_b;
    logic [3:0]  addr_a, addr_b;
    logic [15:0] din_a, din_b;
    logic [15:0] dout_a0, dout_b0, dout_a1, dout_b1;
    logic        busy0, busy1;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        int          due;
        int          sig;   // 0 dout_a, 1 dout_b, 2 init_busy
        int          dut;   // 0 read-first, 1 write-first
        logic [15:0] exp;
        string       name;
    } exp_t;

    exp_t exp_q[$];

    ram_dp_sr_sw_be #(.DATA_W(16), .ADDR_W(4), .RD_MODE(0), .INIT_CLR(1), .INIT_VAL(16'hA5A5)) dut0 (
        .clk(clk), .resetn(resetn),
        .cs_a(cs_a), .we_a(we_a), .oe_a(oe_a), .be_a(be_a), .addr_a(addr_a), .din_a(din_a), .dout_a(dout_a0),
        .cs_b(cs_b), .we_b(we_b), .oe_b(oe_b), .be_b(be_b), .addr_b(addr_b), .din_b(din_b), .dout_b(dout_b0),
        .init_busy(busy0)
    );

    ram_dp_sr_sw_be #(.DATA_W(16), .ADDR_W(4), .RD_MODE(1), .INIT_CLR(1), .INIT_VAL(16'hA5A5)) dut1 (
        .clk(clk), .resetn(resetn),
        .cs_a(cs_a), .we_a(we_a), .oe_a(oe_a), .be_a(be_a), .addr_a(addr_a), .din_a(din_a), .dout_a(dout_a1),
        .cs_b(cs_b), .we_b(we_b), .oe_b(oe_b), .be_b(be_b), .addr_b(addr_b), .din_b(din_b), .dout_b(dout_b1),
        .init_busy(busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] pick(input int sig, input int dut);
        logic [15:0] v;
        v = '0;
        case (sig)
            0:       v = (dut == 0) ? dout_a0 : dout_a1;
            1:       v = (dut == 0) ? dout_b0 : dout_b1;
            default: v = {15'b0, (dut == 0) ? busy0 : busy1};
        endcase
        return v;
    endfunction

    // Monitor: compare every expectation that falls due this cycle.
    always @(negedge clk) begin : monitor
        int          i;
        logic [15:0] act;
        i = 0;
        while (i < exp_q.size()) begin
            if (exp_q[i].due == cyc) begin
                act = pick(exp_q[i].sig, exp_q[i].dut);
                checks++;
                if (act !== exp_q[i].exp) begin
                    errors++;
                    $display("FAIL %s dut%0d cyc %0d got %h expected %h",
                             exp_q[i].name, exp_q[i].dut, cyc, act, exp_q[i].exp);
                end else begin
                    $display("ok   %s dut%0d cyc %0d value %h",
                             exp_q[i].name, exp_q[i].dut, cyc, act);
                end
                exp_q.delete(i);
            end else begin
                i++;
            end
        end
    end

    task automatic pushd(input int sig, input int dly, input logic [15:0] e0,
                         input logic [15:0] e1, input string name);
        exp_t e;
        e.due = cyc + dly; e.sig = sig; e.name = name;
        e.dut = 0; e.exp = e0; exp_q.push_back(e);
        e.dut = 1; e.exp = e1; exp_q.push_back(e);
    endtask

    task automatic push2(input int sig, input logic [15:0] e0, input logic [15:0] e1,
                         input string name);
        pushd(sig, 1, e0, e1, name);
    endtask

    // Advance to just after the next falling edge and drop all strobes.
    task automatic step();
        @(negedge clk);
        #1;
        cs_a = 0; we_a = 0; be_a = 2'b00;
        cs_b = 0; we_b = 0; be_b = 2'b00;
    endtask

    task automatic wr_a(input logic [3:0] a, input logic [15:0] d, input logic [1:0] be);
        cs_a = 1; we_a = 1; addr_a = a; din_a = d; be_a = be;
    endtask

    task automatic wr_b(input logic [3:0] a, input logic [15:0] d, input logic [1:0] be);
        cs_b = 1; we_b = 1; addr_b = a; din_b = d; be_b = be;
    endtask

    task automatic rd_a(input logic [3:0] a);
        cs_a = 1; we_a = 0; addr_a = a;
    endtask

    task automatic rd_b(input logic [3:0] a);
        cs_b = 1; we_b = 0; addr_b = a;
    endtask

    initial begin
        resetn = 0; oe_a = 1; oe_b = 1;
        cs_a = 0; we_a = 0; be_a = 0; addr_a = 0; din_a = 0;
        cs_b = 0; we_b = 0; be_b = 0; addr_b = 0; din_b = 0;

        // Reset state
        step();
        push2(0, 16'h0000, 16'h0000, "rst_dout_a");
        push2(1, 16'h0000, 16'h0000, "rst_dout_b");
        push2(2, 16'h0001, 16'h0001, "rst_busy");
        step();

        // Release: busy must stay high for exactly 16 edges
        step();
        resetn = 1;
        for (int k = 1; k <= 16; k++) pushd(2, k, (k < 16) ? 16'h1 : 16'h0, (k < 16) ? 16'h1 : 16'h0, "clr_busy");
        for (int k = 1; k < 16; k++) begin
            step();
            if (k == 3) wr_a(4'd2, 16'h1111, 2'b11);
            rd_b(k[3:0]);
            push2(1, 16'h0000, 16'h0000, "clr_rd_held");
        end

        // Cleared contents
        step(); rd_a(4'd0);  push2(0, 16'hA5A5, 16'hA5A5, "clr_addr0");
        step(); rd_a(4'd15); push2(0, 16'hA5A5, 16'hA5A5, "clr_addr15");
        step(); rd_a(4'd2);  push2(0, 16'hA5A5, 16'hA5A5, "clr_blocked_wr");

        // Byte write, latency and output enable
        step(); wr_a(4'd3, 16'h1234, 2'b11);
        step(); wr_a(4'd3, 16'hFFFF, 2'b01);
        step(); rd_b(4'd3); push2(1, 16'h12FF, 16'h12FF, "byte_wr_latency");
        step(); oe_b = 0;   push2(1, 16'h0000, 16'h0000, "oe_off");
        step(); oe_b = 1;   push2(1, 16'h12FF, 16'h12FF, "oe_hold");

        // Same-port read-during-write
        step(); wr_a(4'd5, 16'h0001, 2'b11);
        step(); wr_a(4'd5, 16'h0002, 2'b11); push2(0, 16'h0001, 16'h0002, "rdw_mode");
        step(); rd_a(4'd5); push2(0, 16'h0002, 16'h0002, "rdw_stored");

        // Same-address double write
        step(); wr_a(4'd7, 16'hAA00, 2'b10); wr_b(4'd7, 16'h55BB, 2'b11);
        push2(0, 16'hA5A5, 16'hAABB, "coll_rdw_a");
        push2(1, 16'hA5A5, 16'hAABB, "coll_rdw_b");
        step(); rd_a(4'd7); push2(0, 16'hAABB, 16'hAABB, "coll_merge");

        // Reader vs writer on one address
        step(); wr_a(4'd9, 16'h0000, 2'b11);
        step(); rd_a(4'd9); wr_b(4'd9, 16'h7777, 2'b11);
        push2(0, 16'h0000, 16'h0000, "xport_rd_old");
        push2(1, 16'h0000, 16'h7777, "xport_wr_rdw");
        step(); rd_a(4'd9); rd_b(4'd9);
        push2(0, 16'h7777, 16'h7777, "both_rd_a");
        push2(1, 16'h7777, 16'h7777, "both_rd_b");

        // Independent writes on different addresses, then be=0
        step(); wr_a(4'd10, 16'h1111, 2'b11); wr_b(4'd11, 16'h2222, 2'b11);
        step(); rd_a(4'd10); rd_b(4'd11);
        push2(0, 16'h1111, 16'h1111, "dual_wr_a");
        push2(1, 16'h2222, 16'h2222, "dual_wr_b");
        step(); wr_a(4'd10, 16'hFFFF, 2'b00); push2(0, 16'h1111, 16'h1111, "be0_rdw");
        step(); rd_a(4'd10); push2(0, 16'h1111, 16'h1111, "be0_no_write");

        // Reset with non-zero read data
        step(); resetn = 0;
        push2(0, 16'h0000, 16'h0000, "rst2_dout_a");
        push2(1, 16'h0000, 16'h0000, "rst2_dout_b");
        step();
        step(); resetn = 1;
        for (int k = 1; k <= 7; k++) step();

        // Reset during clear cycle 8, then full restart
        step(); resetn = 0;
        push2(0, 16'h0000, 16'h0000, "midclr_dout_a");
        push2(2, 16'h0001, 16'h0001, "midclr_busy");
        step();
        step(); resetn = 1;
        for (int k = 1; k <= 16; k++) pushd(2, k, (k < 16) ? 16'h1 : 16'h0, (k < 16) ? 16'h1 : 16'h0, "reclr_busy");
        for (int k = 1; k < 16; k++) step();
        for (int k = 0; k < 16; k++) begin
            step();
            rd_a(k[3:0]);
            rd_b(4'(15 - k));
            push2(0, 16'hA5A5, 16'hA5A5, "reclr_word_a");
            push2(1, 16'hA5A5, 16'hA5A5, "reclr_word_b");
        end

        step(); step(); step();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain left %0d expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ram_dp_sr_sw_be.md
Name: ram_dp_sr_sw_be

Overview:
- Parametrised true dual-port RAM; the next generation of the single-port sync-read/sync-write RAM.
- Two independent synchronous read/write ports (A, B) share one array. Each port has cs/we/oe control, per-byte write enables and a selectable read-during-write mode.
- After reset, a built-in clear sequencer initialises the whole array.
- Intended as the general on-chip buffer for proto-level datapaths.

Parameters:
- DATA_W, 16, data width in bits; must be a multiple of 8.
- ADDR_W, 4, address width; DEPTH = 2**ADDR_W words.
- RD_MODE, 0, same-port read-during-write result: 0 = read-first (old data), 1 = write-first (merged new data).
- INIT_CLR, 1, 1 = run the clear sequencer after reset; 0 = no clear, array contents undefined.
- INIT_VAL, 0, DATA_W-bit value written to every word by the clear sequencer.

Ports:
- clk, input, 1, clock; all logic on the rising edge.
- resetn, input, 1, asynchronous active-low reset.
- cs_a, input, 1, port A chip select.
- we_a, input, 1, port A write enable; qualified by cs_a.
- oe_a, input, 1, port A output enable.
- be_a, input, DATA_W/8, port A byte write enables.
- addr_a, input, ADDR_W, port A address.
- din_a, input, DATA_W, port A write data.
- dout_a, output, DATA_W, port A read data.
- cs_b / we_b / oe_b / be_b / addr_b / din_b / dout_b: identical set for port B.
- init_busy, output, 1, high while the clear sequencer runs.

Behaviour:
- Interface: one clock (clk); reset resetn is asynchronous, active-low.
- Reset asserted:
  - rdata_a_q = rdata_b_q = 0, so dout_a = dout_b = 0.
  - init_busy = INIT_CLR.
  - FSM goes to CLEAR if INIT_CLR = 1, else IDLE; clear pointer = 0.
  - Array contents are not reset.
- FSM states IDLE and CLEAR:
  - In CLEAR, each cycle writes INIT_VAL to mem[ptr] and increments ptr.
  - The cycle ptr = DEPTH-1 is written, go to IDLE; init_busy falls on that same edge.
  - Total clear duration is exactly DEPTH cycles after the first clk edge with resetn high.
- During CLEAR:
  - All port cs are ignored: no writes, and rdata_*_q are held at 0.
- Reset asserted mid-clear:
  - Immediate return to reset values.
  - On release, the clear restarts from address 0.
- Read (cs=1, we=0):
  - rdata_q <= mem[addr] on the edge, so data appears 1 cycle after the request.
- Write (cs=1, we=1):
  - For each byte i with be[i]=1, mem[addr][8i+7:8i] <= din[8i+7:8i]; other bytes are unchanged.
  - be = 0 performs no write.
- Same-port read-during-write (the write cycle also updates rdata_q):
  - RD_MODE=0: rdata_q gets the pre-write word.
  - RD_MODE=1: rdata_q gets the byte-merged post-write word.
- cs=0: no access; rdata_q holds its previous value.
- Output enable:
  - dout = oe ? rdata_q : 0, combinational.
  - oe does not affect rdata_q or writes.
- Cross-port, same address, same cycle:
  - Both write: per byte, port A wins where be_a[i]=1; port B's byte applies only where be_a[i]=0 and be_b[i]=1.
  - One port writes, the other reads: the reader always gets the pre-write word, independent of RD_MODE.
  - Both read: both get the same word.
- Address range: all 2**ADDR_W addresses are valid; there is no out-of-range condition.

Test Plan:
- Init clear (INIT_VAL=16'hA5A5): release resetn → init_busy high for exactly 16 cycles; then reading addr 0 and addr 15 on port A returns 16'hA5A5 one cycle after each request.
- Byte write / latency: A writes addr 3 = 16'h1234 with be=2'b11, then din 16'hFFFF with be=2'b01. B reads addr 3 → dout_b = 16'h12FF exactly 1 cycle after the request; with oe_b=0, dout_b = 0 while rdata_b_q stays 16'h12FF.
- Read-during-write: mem[5]=16'h0001; A writes 16'h0002 to addr 5 with cs/we both high. RD_MODE=0 → dout_a = 16'h0001 next cycle; RD_MODE=1 → 16'h0002.
- Collision: A (be=2'b10, 16'hAA00) and B (be=2'b11, 16'h55BB) write addr 7 in the same cycle → mem[7] = 16'hAABB. A reads addr 9 while B writes 16'h7777 there (old value 16'h0000) → dout_a = 16'h0000.
- Reset mid-clear: assert resetn low at clear cycle 8 → dout = 0 and init_busy stays high; after release, init_busy stays high a full 16 cycles and all words read INIT_VAL.
- Clear blocking: cs_a=1, we_a=1 to addr 2 issued during CLEAR → ignored; mem[2] reads INIT_VAL afterwards.
